// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, N_ITER = WIDTH/2+1 clocks per
// product, signed or unsigned per operation, one-cycle done strobe when R updates.
module booth_mult_r4 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] R
);

  localparam int unsigned N_ITER = WIDTH / 2 + 1;
  localparam int unsigned ExtW   = WIDTH + 2;
  localparam int unsigned HiW    = WIDTH + 4;
  localparam int unsigned CntW   = $clog2(N_ITER + 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth_mult_r4: WIDTH must be even and >= 4");
  end

  typedef enum logic {StIdle, StCalc} state_e;

  state_e               state_q, state_d;
  logic [ExtW-1:0]      m_q, m_d;
  logic [HiW-1:0]       hi_q, hi_d;
  // Multiplier bits above a trailing b[-1] slot; the low three bits are the current Booth window.
  logic [ExtW:0]        lo_q, lo_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   r_q, r_d;
  logic                 done_q, done_d;

  logic [HiW-1:0]             m_ext;
  logic [HiW-1:0]             addend;
  logic [HiW-1:0]             sum;
  logic signed [HiW+ExtW:0]   shifted;

  always_comb begin
    m_ext = {{2{m_q[ExtW-1]}}, m_q};
    unique case (lo_q[2:0])
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum     = hi_q + addend;
    shifted = $signed({sum, lo_q}) >>> 2;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          m_d     = sgn ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
          lo_d    = {(sgn ? {{2{B[WIDTH-1]}}, B} : {2'b00, B}), 1'b0};
          hi_d    = '0;
          cnt_d   = CntW'(N_ITER - 1);
          state_d = StCalc;
        end
      end
      StCalc: begin
        hi_d = shifted[HiW+ExtW:ExtW+1];
        lo_d = shifted[ExtW:0];
        if (cnt_q == '0) begin
          // Product sits in {hi, lo[ExtW:1]}; keep its low 2*WIDTH bits.
          r_d     = shifted[2*WIDTH:1];
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == StCalc);
  assign done = done_q;
  assign R    = r_q;

endmodule
